// File: rtl/image_streamer_pkg.sv
// Shared definitions for the CNN frame streamer: FSM encoding, width helpers
// and the flush-length formula tied to the window buffer's kernel size.
package image_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DRAIN  = 2'd3
    } stream_state_e;

    localparam int KERNEL_WIDTH  = 5;
    localparam int KERNEL_HEIGHT = 5;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic int frame_pixels(input int width, input int height);
        return width * height;
    endfunction

    // Zeros needed for a kernel_h x kernel_w window to slide past the last pixel.
    function automatic int default_flush(input int kernel_w, input int kernel_h, input int width);
        return (kernel_h + 1) / 2 * width + (kernel_w + 1) / 2;
    endfunction

endpackage

// File: rtl/image_streamer_issue_pipe.sv
// Two-stage issue-to-output pipeline: each slot's {valid, is_flush, last} tag
// travels with it so RAM data and flush zeros leave in issue order.
module stream_issue_pipe
    import image_streamer_pkg::*;
#(
    parameter int dataWidth = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_issue_vld,
    input  logic                 i_issue_flush,
    input  logic                 i_issue_last,
    input  logic [dataWidth-1:0] i_mem_data,
    output logic [dataWidth-1:0] o_pixel_data,
    output logic                 o_pixel_data_valid,
    output logic                 o_done
);

    logic                 vld_p1_q, vld_p1_d;
    logic                 flush_p1_q, flush_p1_d;
    logic                 last_p1_q, last_p1_d;
    logic                 vld_p2_q, vld_p2_d;
    logic                 last_p2_q, last_p2_d;
    logic [dataWidth-1:0] data_p2_q, data_p2_d;

    always_comb begin
        vld_p1_d   = i_issue_vld;
        flush_p1_d = i_issue_vld & i_issue_flush;
        last_p1_d  = i_issue_vld & i_issue_last;
        // Stage 1 -> 2: RAM data for this slot is present now, one cycle after the read.
        vld_p2_d   = vld_p1_q;
        last_p2_d  = last_p1_q;
        data_p2_d  = (vld_p1_q && !flush_p1_q) ? i_mem_data : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1_q   <= 1'b0;
            flush_p1_q <= 1'b0;
            last_p1_q  <= 1'b0;
            vld_p2_q   <= 1'b0;
            last_p2_q  <= 1'b0;
            data_p2_q  <= '0;
        end else begin
            vld_p1_q   <= vld_p1_d;
            flush_p1_q <= flush_p1_d;
            last_p1_q  <= last_p1_d;
            vld_p2_q   <= vld_p2_d;
            last_p2_q  <= last_p2_d;
            data_p2_q  <= data_p2_d;
        end
    end

    assign o_pixel_data       = data_p2_q;
    assign o_pixel_data_valid = vld_p2_q;
    assign o_done             = last_p2_q;

endmodule

// File: rtl/image_streamer.sv
// Frame producer for the sliding-window buffer: reads one image row-major from
// a synchronous RAM, then appends flushPixels zeros so the buffer drains.
module image_streamer
    import image_streamer_pkg::*;
#(
    parameter int dataWidth   = 1,
    parameter int imageWidth  = 256,
    parameter int imageHeight = 256,
    parameter int addrWidth   = 16,
    parameter int baseAddr    = 0,
    parameter int flushPixels = default_flush(KERNEL_WIDTH, KERNEL_HEIGHT, imageWidth)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_hold,
    output logic                 o_mem_rd_en,
    output logic [addrWidth-1:0] o_mem_addr,
    input  logic [dataWidth-1:0] i_mem_data,
    output logic [dataWidth-1:0] o_pixel_data,
    output logic                 o_pixel_data_valid,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int FRAME_PIXELS = frame_pixels(imageWidth, imageHeight);
    localparam int IDX_W        = clog2(FRAME_PIXELS + 1);
    localparam int FL_W         = (clog2(flushPixels + 1) < 1) ? 1 : clog2(flushPixels + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_PIXELS - 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(flushPixels - 1);

    stream_state_e        state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [FL_W-1:0]      fl_q, fl_d;
    logic [addrWidth-1:0] addr_q, addr_d;
    logic [addrWidth-1:0] rd_addr;
    logic                 rd_en;
    logic                 issue_vld;
    logic                 issue_flush;
    logic                 issue_last;
    logic                 pipe_done;

    assign rd_addr = addrWidth'(baseAddr) + addrWidth'(idx_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        fl_d        = fl_q;
        addr_d      = addr_q;
        rd_en       = 1'b0;
        issue_vld   = 1'b0;
        issue_flush = 1'b0;
        issue_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_STREAM;
                    idx_d   = '0;
                    fl_d    = '0;
                end
            end
            ST_STREAM: begin
                if (!i_hold) begin
                    rd_en     = 1'b1;
                    issue_vld = 1'b1;
                    addr_d    = rd_addr;
                    idx_d     = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        if (flushPixels > 0) begin
                            state_d = ST_FLUSH;
                        end else begin
                            state_d    = ST_DRAIN;
                            issue_last = 1'b1;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (!i_hold) begin
                    issue_vld   = 1'b1;
                    issue_flush = 1'b1;
                    fl_d        = fl_q + FL_W'(1);
                    if (fl_q == FL_LAST) begin
                        state_d    = ST_DRAIN;
                        issue_last = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // The tagged last slot reaching the output means nothing else is in flight.
                if (pipe_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            fl_q    <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fl_q    <= fl_d;
            addr_q  <= addr_d;
        end
    end

    stream_issue_pipe #(
        .dataWidth(dataWidth)
    ) u_issue_pipe (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_issue_vld        (issue_vld),
        .i_issue_flush      (issue_flush),
        .i_issue_last       (issue_last),
        .i_mem_data         (i_mem_data),
        .o_pixel_data       (o_pixel_data),
        .o_pixel_data_valid (o_pixel_data_valid),
        .o_done             (pipe_done)
    );

    assign o_mem_rd_en = rd_en;
    assign o_mem_addr  = rd_en ? rd_addr : addr_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = pipe_done;

endmodule

// File: tb/tb_image_streamer.sv
// Bench for image_streamer: two 4x3 instances (flush 2 / base 0, flush 0 / base 100)
// checked against a slot-issue model derived from the stream rules.
module tb_image_streamer;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int NPIX = 12;

    logic          clk = 1'b0;
    logic          a_rst_n = 1'b0, b_rst_n = 1'b0;
    logic          a_start = 1'b0, b_start = 1'b0;
    logic          a_hold = 1'b0, b_hold = 1'b0;
    logic          a_rd, b_rd, a_vld, b_vld, a_busy, b_busy, a_done, b_done;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_mdata = '0, b_mdata = '0, a_pix, b_pix;
    logic [DW-1:0] ram [256];

    int ncmp = 0;
    int nfail = 0;
    bit sel = 1'b0;

    int            obs_vcyc[$], obs_rcyc[$], obs_raddr[$], obs_done[$], obs_busy[$];
    logic [DW-1:0] obs_val[$];
    int            viol;

    always #5 clk = ~clk;

    image_streamer #(.dataWidth(DW), .imageWidth(4), .imageHeight(3), .addrWidth(AW),
                     .baseAddr(0), .flushPixels(2)) dut_a (
        .i_clk(clk), .i_rst_n(a_rst_n), .i_start(a_start), .i_hold(a_hold),
        .o_mem_rd_en(a_rd), .o_mem_addr(a_addr), .i_mem_data(a_mdata),
        .o_pixel_data(a_pix), .o_pixel_data_valid(a_vld), .o_busy(a_busy), .o_done(a_done));

    image_streamer #(.dataWidth(DW), .imageWidth(4), .imageHeight(3), .addrWidth(AW),
                     .baseAddr(100), .flushPixels(0)) dut_b (
        .i_clk(clk), .i_rst_n(b_rst_n), .i_start(b_start), .i_hold(b_hold),
        .o_mem_rd_en(b_rd), .o_mem_addr(b_addr), .i_mem_data(b_mdata),
        .o_pixel_data(b_pix), .o_pixel_data_valid(b_vld), .o_busy(b_busy), .o_done(b_done));

    always @(posedge clk) begin
        if (a_rd) a_mdata <= ram[a_addr];
        if (b_rd) b_mdata <= ram[b_addr];
    end

    wire          s_rd   = sel ? b_rd   : a_rd;
    wire          s_vld  = sel ? b_vld  : a_vld;
    wire          s_busy = sel ? b_busy : a_busy;
    wire          s_done = sel ? b_done : a_done;
    wire [AW-1:0] s_addr = sel ? b_addr : a_addr;
    wire [DW-1:0] s_pix  = sel ? b_pix  : a_pix;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "/rd_en"}, s_rd, 0);
        chk({tag, "/addr"},  s_addr, 0);
        chk({tag, "/pix"},   s_pix, 0);
        chk({tag, "/vld"},   s_vld, 0);
        chk({tag, "/busy"},  s_busy, 0);
        chk({tag, "/done"},  s_done, 0);
    endtask

    // Drives one frame cycle by cycle; cycle 0 is the cycle whose start bit is spat[0].
    task automatic run_frame(input bit which, input logic [63:0] hpat, input logic [63:0] spat,
                             input int ncyc, input int rst_cyc);
        sel = which;
        obs_vcyc.delete(); obs_val.delete(); obs_rcyc.delete();
        obs_raddr.delete(); obs_done.delete(); obs_busy.delete();
        viol = 0;
        for (int c = 0; c < ncyc; c++) begin
            #1;
            if (which) begin b_start = spat[c]; b_hold = hpat[c]; end
            else       begin a_start = spat[c]; a_hold = hpat[c]; end
            if (c == rst_cyc) begin
                if (which) b_rst_n = 1'b0; else a_rst_n = 1'b0;
                #1;
                chk_outputs_zero("mid_frame_reset");
            end
            if (c == rst_cyc + 1) begin
                if (which) b_rst_n = 1'b1; else a_rst_n = 1'b1;
            end
            @(negedge clk);
            if (s_vld)  begin obs_vcyc.push_back(c); obs_val.push_back(s_pix); end
            if (s_rd)   begin obs_rcyc.push_back(c); obs_raddr.push_back(int'(s_addr)); end
            if (s_done) obs_done.push_back(c);
            if (s_busy) obs_busy.push_back(c);
            if (s_rd && (which ? b_hold : a_hold)) viol++;
            @(posedge clk);
        end
        a_start = 1'b0; a_hold = 1'b0; b_start = 1'b0; b_hold = 1'b0;
    endtask

    // Model: slot k (reads 0..11, then flush zeros) is issued in the k-th non-held cycle
    // from cycle 1 on and appears at the output two cycles later; events at or after
    // cutoff are lost to a reset.
    task automatic compare_run(input string tag, input int nflush, input int base,
                               input logic [63:0] hpat, input int cutoff);
        int iss[$];
        int ev[$], er[$], ea[$];
        logic [DW-1:0] evl[$];
        int c, k, done_c, busy_end, ndone;
        c = 1; k = 0;
        while (k < NPIX + nflush && c < 64) begin
            if (!hpat[c]) begin iss.push_back(c); k++; end
            c++;
        end
        for (int i = 0; i < iss.size(); i++) begin
            if (iss[i] + 2 < cutoff) begin
                ev.push_back(iss[i] + 2);
                evl.push_back(i < NPIX ? ram[base + i] : '0);
            end
            if (i < NPIX && iss[i] < cutoff) begin
                er.push_back(iss[i]);
                ea.push_back(base + i);
            end
        end
        done_c   = iss[iss.size() - 1] + 2;
        ndone    = (done_c < cutoff) ? 1 : 0;
        busy_end = (done_c < cutoff) ? done_c : cutoff - 1;

        chk({tag, "/n_valid"}, obs_vcyc.size(), ev.size());
        for (int i = 0; i < ev.size(); i++) begin
            chk($sformatf("%s/vcyc[%0d]", tag, i), i < obs_vcyc.size() ? obs_vcyc[i] : -1, ev[i]);
            chk($sformatf("%s/pix[%0d]", tag, i), i < obs_val.size() ? obs_val[i] : 'x, evl[i]);
        end
        chk({tag, "/n_reads"}, obs_rcyc.size(), er.size());
        for (int i = 0; i < er.size(); i++) begin
            chk($sformatf("%s/rcyc[%0d]", tag, i), i < obs_rcyc.size() ? obs_rcyc[i] : -1, er[i]);
            chk($sformatf("%s/raddr[%0d]", tag, i), i < obs_raddr.size() ? obs_raddr[i] : -1, ea[i]);
        end
        chk({tag, "/n_done"}, obs_done.size(), ndone);
        if (ndone == 1) chk({tag, "/done_cyc"}, obs_done.size() > 0 ? obs_done[0] : -1, done_c);
        chk({tag, "/n_busy"}, obs_busy.size(), busy_end);
        for (int i = 0; i < obs_busy.size(); i++)
            chk($sformatf("%s/busy[%0d]", tag, i), obs_busy[i], i + 1);
        chk({tag, "/rd_while_hold"}, viol, 0);
    endtask

    initial begin
        logic [63:0] hp;
        for (int i = 0; i < 256; i++) ram[i] = DW'(i);

        repeat (3) @(posedge clk);
        #1;
        sel = 1'b0; #1; chk_outputs_zero("reset_a");
        sel = 1'b1; #1; chk_outputs_zero("reset_b");
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        @(posedge clk);

        // Basic frame, RAM[i]=i, no stalls.
        run_frame(1'b0, 64'h0, 64'h1, 24, -1);
        compare_run("basic", 2, 0, 64'h0, 1000);
        chk("basic/first_valid_cyc", obs_vcyc.size() > 0 ? obs_vcyc[0] : -1, 3);
        chk("basic/done_cyc16", obs_done.size() > 0 ? obs_done[0] : -1, 16);

        // Stall in cycles 5..7.
        run_frame(1'b0, 64'h00E0, 64'h1, 26, -1);
        compare_run("hold_5_7", 2, 0, 64'h00E0, 1000);

        // Stall in the first flush cycle.
        run_frame(1'b0, 64'h2000, 64'h1, 26, -1);
        compare_run("hold_first_flush", 2, 0, 64'h2000, 1000);

        // Start re-pulsed mid-frame and on the done cycle.
        run_frame(1'b0, 64'h0, 64'h1_0011, 40, -1);
        compare_run("restart_ignored", 2, 0, 64'h0, 1000);

        for (int i = 0; i < 256; i++) ram[i] = DW'($urandom);

        // No flush phase, base address 100.
        run_frame(1'b1, 64'h0, 64'h1, 24, -1);
        compare_run("no_flush", 0, 100, 64'h0, 1000);

        for (int t = 0; t < 4; t++) begin
            hp = {$urandom, $urandom} & {$urandom, $urandom} & 64'h0000_00FF_FFFF_FFFE;
            run_frame(t[0], hp, 64'h1, 60, -1);
            compare_run($sformatf("rand%0d", t), t[0] ? 0 : 2, t[0] ? 100 : 0, hp, 1000);
        end

        // Reset asserted in cycle 8, then a fresh frame from baseAddr.
        run_frame(1'b1, 64'h0, 64'h1, 24, 8);
        compare_run("reset_abort", 0, 100, 64'h0, 8);
        hp = {$urandom, $urandom} & 64'h0000_0000_00FF_FFFE;
        run_frame(1'b1, hp, 64'h1, 60, -1);
        compare_run("after_reset", 0, 100, hp, 1000);
        chk("after_reset/first_addr", obs_raddr.size() > 0 ? obs_raddr[0] : -1, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/image_streamer.md
Name: image_streamer

Overview:
- Frame-level producer that feeds the sliding-window image buffer of the CNN datapath.
- On a start pulse it reads one image, row-major, from a synchronous frame RAM through a read port. It emits the pixels as a valid-qualified stream that connects directly to the window buffer's pixel/valid inputs.
- After the last image pixel it appends a programmable run of zero-valued flush pixels, so the downstream window buffer drains its final rows.

Parameters:
- dataWidth, 1, pixel width in bits
- imageWidth, 256, pixels per row
- imageHeight, 256, rows per frame
- addrWidth, 16, frame RAM address width; must satisfy 2^addrWidth >= imageWidth*imageHeight
- baseAddr, 0, RAM address of pixel (0,0)
- flushPixels, 771, zero pixels appended after the frame; 0 means no flush phase

Ports:
- i_clk, in, 1, clock
- i_rst_n, in, 1, asynchronous active-low reset
- i_start, in, 1, single-cycle frame start request
- i_hold, in, 1, stall: no new reads or flush pixels are issued while high
- o_mem_rd_en, out, 1, RAM read strobe
- o_mem_addr, out, addrWidth, RAM read address
- i_mem_data, in, dataWidth, RAM read data, valid one cycle after o_mem_rd_en
- o_pixel_data, out, dataWidth, pixel to the window buffer
- o_pixel_data_valid, out, 1, pixel qualifier
- o_busy, out, 1, frame in progress
- o_done, out, 1, single-cycle end-of-frame pulse

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs go to 0, the FSM goes to IDLE, and all counters and pipeline tags clear.
  - A reset mid-frame aborts the frame silently: no o_done, and no further valid pixels.
- FSM states: IDLE, STREAM, FLUSH, DRAIN.
  - IDLE -> STREAM on i_start=1. i_start is ignored in every other state.
  - STREAM -> FLUSH when the read of the last pixel (index imageWidth*imageHeight-1) is issued and flushPixels>0. If flushPixels=0, STREAM -> DRAIN instead.
  - FLUSH -> DRAIN when the last flush slot is issued.
  - DRAIN -> IDLE when the issue pipeline is empty, i.e. the cycle after the last o_pixel_data_valid.
- Issue rules:
  - In STREAM with i_hold=0, assert o_mem_rd_en and set o_mem_addr = baseAddr + pixel index, then increment the index. With i_hold=1, o_mem_rd_en=0 and the index holds.
  - The first read is issued in the cycle after i_start.
  - In FLUSH with i_hold=0, one flush slot is issued per cycle; o_mem_rd_en stays 0.
  - o_mem_addr holds its last value when not reading; its value is don't-care when o_mem_rd_en=0.
- Issue-to-output pipeline:
  - Each issued slot (read or flush) carries a tag {valid, is_flush} through 2 register stages.
  - o_pixel_data_valid is asserted exactly 2 cycles after its slot was issued.
  - o_pixel_data is the registered i_mem_data for read slots and 0 for flush slots.
  - Because the tag travels with the slot, the last image pixel and the first flush pixel never collide or reorder. The output sequence is all image pixels, then all flush pixels, with gaps only where i_hold stalled issue.
  - Reads already in flight when i_hold rises still complete and are emitted. i_hold does not gate the output.
- o_busy rises in the cycle after i_start is accepted and falls in the cycle after o_done.
- o_done is asserted in the same cycle as the final o_pixel_data_valid (the last flush pixel, or the last image pixel when flushPixels=0).
- Total valid pixels per frame = imageWidth*imageHeight + flushPixels, exactly.
- Width rules:
  - Pixel index counter: clog2(imageWidth*imageHeight+1) bits.
  - Flush counter: clog2(flushPixels+1) bits, minimum 1.
  - Address sum is truncated to addrWidth.
- A start request in the same cycle as o_done is ignored; a new start is accepted only from IDLE.

Decomposition:
- Shared cnn package:
  - FSM state encoding.
  - Constant function clog2.
  - Derived constant FRAME_PIXELS = imageWidth*imageHeight.
  - Default flush value (kernelHeight+1)/2*imageWidth + (kernelWidth+1)/2, so instances tied to a kernel size compute it consistently.
- Sub-module: stream_issue_pipe, the 2-stage tag/data pipeline that muxes RAM data or zero.

Test Plan:
- imageWidth=4, imageHeight=3, flushPixels=2, RAM[i]=i, start at cycle 0 -> reads of addresses 0..11 in cycles 1..12; valid pixels 0..11 in cycles 3..14; zeros in cycles 15..16; o_done in cycle 16; o_busy high in cycles 1..16.
- Same config with i_hold=1 in cycles 5..7 -> no reads in cycles 5..7; the reads issued in cycles 3 and 4 still emit in cycles 5..6; output gap in cycles 7..9; totals are still 12 pixels + 2 zeros, in order.
- flushPixels=0 -> o_done coincides with pixel 11; the FSM never enters FLUSH; exactly 12 valid pixels.
- i_start re-pulsed in cycles 4 and 16 -> ignored; no second frame; the pixel count is unchanged.
- i_rst_n low in cycle 8 -> all outputs 0 asynchronously; no o_done; after release, a fresh i_start streams from address baseAddr (set baseAddr=100 -> first read at address 100).
- i_hold held high in the cycle after the last image read (the first flush cycle) -> the flush is delayed and no zero precedes pixel 11.
